red_seq: RTL and testbench
==========================

# red_seq

Multi-cycle sequencer for the RED (reduction) instruction in the WISC execute stage. It latches two 16-bit operands and computes the reduction nibble by nibble through a single shared 4-bit carry-lookahead adder slice, replacing the wide combinational reduction tree. A start/busy/done handshake lets the pipeline stall-control unit hold the pipeline while a reduction is in flight, and a flush input aborts a pending reduction.

## Interface
- No parameters; widths fixed at 16-bit data, 4-bit adder slice.
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a reduction; sampled only when the FSM can accept.
- flush  input  1  abort the in-flight reduction; highest priority after rst.
- rs  input  16  operand Rs; captured on the accepting edge.
- rt  input  16  operand Rt; captured on the accepting edge.
- rd  output  16  reduction result; holds its value until the next DONE.
- busy  output  1  high while a computation is in flight (states LO0..F2).
- done  output  1  one-cycle pulse; rd valid in the same cycle.

## Operation
- Function: rd = sext16(S), with S = sext12(A) + sext12(B) computed over 12 bits.
  - A = sext9(rs[7:0]) + sext9(rt[7:0]), signed 9-bit.
  - B = sext9(rs[15:8]) + sext9(rt[15:8]), signed 9-bit.
  - S range is -512..+508; no overflow is possible.
- Datapath: one 4-bit CLA slice, 1-bit carry register, 9-bit A and B registers, 12-bit S register, operand registers.
- FSM states: IDLE, LO0, LO1, HI0, HI1, F0, F1, F2, DONE.
- IDLE: on start=1, latch rs and rt, clear carry, go to LO0. Otherwise stay in IDLE.
- LO0: A[3:0] = rs[3:0] + rt[3:0] + 0; carry registered.
- LO1: A[7:4] = rs[7:4] + rt[7:4] + carry. A[8] = rs[7]^rt[7]^carry-out (signed 9th bit). Carry cleared.
- HI0 and HI1: same operation on rs[15:8] and rt[15:8], producing B.
- F0: S[3:0] = A[3:0] + B[3:0]. Carry cleared on entry from HI1.
- F1: S[7:4] = A[7:4] + B[7:4] + carry.
- F2: S[11:8] = {4{A[8]}} + {4{B[8]}} + carry. rd <= {{4{S[11]}}, S[11:0]} at the edge leaving F2.
- DONE: done=1 for one cycle, then return to IDLE.
- flush=1 in any state: next state is IDLE; no done pulse; rd keeps its previous value.
- start while busy=1: ignored; operands are not re-latched.
- Reset: state=IDLE, rd=0x0000, busy=0, done=0, all internal registers cleared.

## Timing
- Call the accepting edge E0.
- busy=1 in the 7 cycles after E0 (LO0 through F2).
- done=1 and the new rd are visible in the 8th cycle after E0.
- Throughput without the back-to-back feature: one result per 9 cycles.
- busy and done are registered-state decodes; no combinational path from inputs to outputs.
- rst asserted mid-operation clears everything asynchronously. Operation resumes from IDLE on the first edge after rst deasserts.
- flush and start high on the same edge in IDLE: flush wins, nothing is accepted.

## Configuration
- RED_SEQ_B2B_EN, defined: start=1 in the DONE cycle is accepted. Operands are latched and the FSM goes directly to LO0, giving one result per 8 cycles.
- RED_SEQ_B2B_EN, undefined: start in DONE is ignored. The FSM always passes through IDLE, and start must be presented again there.

## Test plan
- Reset mid-run: assert rst during HI1 -> rd=0x0000, busy=0, done=0 immediately; a new start after release produces a correct result.
- Positive carry across bytes: rs=0x7F7F, rt=0x0101, start -> done 8 cycles later with rd=0x0100; busy high for exactly 7 cycles.
- Negative sign extension: rs=0x8080, rt=0x8080 -> rd=0xFE00.
- Mixed operands with a busy-time start: rs=0x1234, rt=0x5678 -> rd=0x0114. Pulse start again in F0 with other operands -> ignored; rd is still 0x0114 and exactly one done pulse occurs.
- Flush: start with rs=0xFFFF, rt=0x0001, then flush in F1 -> no done pulse, rd keeps its prior value, FSM in IDLE next cycle.
- Back-to-back: hold start high through DONE -> with RED_SEQ_B2B_EN, second done 8 cycles after the first; without it, 9 cycles after.

Source files
------------

// File: rtl/red_seq.sv
// RED reduction sequencer: sign-extended byte sums folded through one 4-bit CLA slice.
// Optional RED_SEQ_B2B_EN accepts a new start in the DONE cycle.
module red_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [15:0] rs,
    input  logic [15:0] rt,
    output logic [15:0] rd,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        IDLE, LO0, LO1, HI0, HI1, F0, F1, F2, DONE
    } state_t;

    state_t      state_q;
    logic [15:0] rs_q;
    logic [15:0] rt_q;
    logic [8:0]  a_q;
    logic [8:0]  b_q;
    logic [7:0]  s_lo_q;
    logic        carry_q;
    logic [15:0] rd_q;
    logic        busy_q;
    logic        done_q;

    logic [3:0]  op_a;
    logic [3:0]  op_b;
    logic [3:0]  g;
    logic [3:0]  p;
    logic [3:0]  c;
    logic        cout;
    logic [3:0]  sum;

    // Operand select for the shared slice, one nibble per state
    always_comb begin
        op_a = 4'h0;
        op_b = 4'h0;
        unique case (state_q)
            LO0:     begin op_a = rs_q[3:0];   op_b = rt_q[3:0];   end
            LO1:     begin op_a = rs_q[7:4];   op_b = rt_q[7:4];   end
            HI0:     begin op_a = rs_q[11:8];  op_b = rt_q[11:8];  end
            HI1:     begin op_a = rs_q[15:12]; op_b = rt_q[15:12]; end
            F0:      begin op_a = a_q[3:0];    op_b = b_q[3:0];    end
            F1:      begin op_a = a_q[7:4];    op_b = b_q[7:4];    end
            F2:      begin op_a = {4{a_q[8]}}; op_b = {4{b_q[8]}}; end
            default: begin op_a = 4'h0;        op_b = 4'h0;        end
        endcase
    end

    always_comb begin
        g    = op_a & op_b;
        p    = op_a ^ op_b;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & carry_q);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & carry_q);
        cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & carry_q);
        sum  = p ^ c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rs_q    <= 16'h0;
            rt_q    <= 16'h0;
            a_q     <= 9'h0;
            b_q     <= 9'h0;
            s_lo_q  <= 8'h0;
            carry_q <= 1'b0;
            rd_q    <= 16'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        rs_q    <= rs;
                        rt_q    <= rt;
                        carry_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= LO0;
                    end
                end
                LO0: begin
                    a_q[3:0] <= sum;
                    carry_q  <= cout;
                    state_q  <= LO1;
                end
                LO1: begin
                    // 9th bit is the sign of the sign-extended byte sum
                    a_q[7:4] <= sum;
                    a_q[8]   <= rs_q[7] ^ rt_q[7] ^ cout;
                    carry_q  <= 1'b0;
                    state_q  <= HI0;
                end
                HI0: begin
                    b_q[3:0] <= sum;
                    carry_q  <= cout;
                    state_q  <= HI1;
                end
                HI1: begin
                    b_q[7:4] <= sum;
                    b_q[8]   <= rs_q[15] ^ rt_q[15] ^ cout;
                    carry_q  <= 1'b0;
                    state_q  <= F0;
                end
                F0: begin
                    s_lo_q[3:0] <= sum;
                    carry_q     <= cout;
                    state_q     <= F1;
                end
                F1: begin
                    s_lo_q[7:4] <= sum;
                    carry_q     <= cout;
                    state_q     <= F2;
                end
                F2: begin
                    rd_q    <= {{4{sum[3]}}, sum, s_lo_q};
                    carry_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
`ifdef RED_SEQ_B2B_EN
                    if (start) begin
                        rs_q    <= rs;
                        rt_q    <= rt;
                        carry_q <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= LO0;
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
`else
                    done_q  <= 1'b0;
                    state_q <= IDLE;
`endif
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rd   = rd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_red_seq.sv
// Directed and random checks of red_seq against an arithmetic reference.
module tb_red_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [15:0] rs;
    logic [15:0] rt;
    logic [15:0] rd;
    logic        busy;
    logic        done;

    int checks;
    int errors;
    int done_cnt;

    red_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .flush (flush),
        .rs    (rs),
        .rt    (rt),
        .rd    (rd),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (done === 1'b1) done_cnt++;

    function automatic logic [15:0] ref_red(input logic [15:0] x,
                                            input logic [15:0] y);
        int a;
        int b;
        int s;
        a = $signed(x[7:0]) + $signed(y[7:0]);
        b = $signed(x[15:8]) + $signed(y[15:8]);
        s = a + b;
        return s[15:0];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // inj: cycle after acceptance (1..7) in which start is pulsed again
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input int inj);
        logic [15:0] exp;
        int          dc0;
        exp   = ref_red(a, b);
        dc0   = done_cnt;
        rs    = a;
        rt    = b;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            chk("busy_run", {15'h0, busy}, 16'h1);
            chk("done_early", {15'h0, done}, 16'h0);
            if (i == inj) begin
                rs    = ~a;
                rt    = a ^ 16'h5A5A;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        chk("done_cyc8", {15'h0, done}, 16'h1);
        chk("rd", rd, exp);
        chk("busy_cyc8", {15'h0, busy}, 16'h0);
        step();
        chk("done_pulse", {15'h0, done}, 16'h0);
        chk("rd_hold", rd, exp);
        step();
        chk("done_count", 16'(done_cnt - dc0), 16'h1);
    endtask

    initial begin
        logic [15:0] prev;
        int          gap;
        int          dc0;
        logic [15:0] ra;
        logic [15:0] rb;
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        rs       = 16'h0;
        rt       = 16'h0;
        repeat (3) step();
        chk("rst_rd", rd, 16'h0);
        chk("rst_busy", {15'h0, busy}, 16'h0);
        chk("rst_done", {15'h0, done}, 16'h0);
        rst = 1'b0;
        step();

        // Reset mid-run in HI1
        rs    = 16'h1357;
        rt    = 16'h2468;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("midrst_rd", rd, 16'h0);
        chk("midrst_busy", {15'h0, busy}, 16'h0);
        chk("midrst_done", {15'h0, done}, 16'h0);
        step();
        rst = 1'b0;
        step();
        run_op(16'h1357, 16'h2468, 0);

        run_op(16'h7F7F, 16'h0101, 0);
        chk("pos_carry", rd, 16'h0100);
        run_op(16'h8080, 16'h8080, 0);
        chk("neg_sext", rd, 16'hFE00);
        run_op(16'h7F7F, 16'h7F7F, 0);
        chk("max_pos", rd, 16'h01FC);
        run_op(16'h1234, 16'h5678, 5);
        chk("busy_start", rd, 16'h0114);

        // Flush in F1
        prev  = rd;
        dc0   = done_cnt;
        rs    = 16'hFFFF;
        rt    = 16'h0001;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", {15'h0, busy}, 16'h0);
        chk("flush_done", {15'h0, done}, 16'h0);
        repeat (10) step();
        chk("flush_nodone", 16'(done_cnt - dc0), 16'h0);
        chk("flush_rd", rd, prev);

        // flush and start together in IDLE
        rs    = 16'h0F0F;
        rt    = 16'h0F0F;
        start = 1'b1;
        flush = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", {15'h0, busy}, 16'h0);
        repeat (10) step();
        chk("flush_start_rd", rd, prev);

        // Back-to-back with start held high
        rs    = 16'h0102;
        rt    = 16'h0304;
        start = 1'b1;
        gap   = -1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done === 1'b1) break;
        end
        chk("b2b_first", {15'h0, done}, 16'h1);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (done === 1'b1) begin
                gap = k;
                break;
            end
        end
        start = 1'b0;
`ifdef RED_SEQ_B2B_EN
        chk("b2b_gap", 16'(gap), 16'd8);
`else
        chk("b2b_gap", 16'(gap), 16'd9);
`endif
        chk("b2b_rd", rd, ref_red(16'h0102, 16'h0304));
        repeat (12) step();

        for (int n = 0; n < 24; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(ra, rb, (n % 3 == 0) ? int'($urandom_range(1, 7)) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
